dmem_lsu_ctrl: RTL and testbench

Load/store sequencer between the RV32I multicycle core and port A of the four-lane byte-sliced data memory. It accepts one load or store per handshake and converts funct3 and the byte address into lane enables, lane-shifted write data and word addresses. It returns sign- or zero-extended load data. When enabled, it splits misaligned accesses into two word accesses. Port B of the memory is not driven by this block.

---
 rtl/dmem_lsu_ctrl.sv | 254 +++++++++++++++++++++++++
 tb/tb_dmem_lsu_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_lsu_ctrl
//  Description : Load/store sequencer between the RV32I multicycle core and
//                port A of the four-lane byte-sliced data memory. Converts
//                funct3 + byte address into lane enables, lane-shifted write
//                data and word addresses, and returns extended load data.
//                Build option DMEM_MISALIGNED_EN: when defined, misaligned
//                accesses are split into two word accesses; otherwise they
//                complete with resp_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_lsu_ctrl #(
    parameter int XLEN       = 32,
    parameter int DMEM_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [XLEN-1:0]       req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_err,
    output logic [DMEM_WIDTH-1:0] mem_address,
    output logic [XLEN-1:0]       mem_data,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [3:0]            mem_byteena,
    input  logic [XLEN-1:0]       mem_q
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_acc0  = 3'd1;
    localparam logic [2:0] c_st_data0 = 3'd2;
`ifdef DMEM_MISALIGNED_EN
    localparam logic [2:0] c_st_acc1  = 3'd3;
    localparam logic [2:0] c_st_data1 = 3'd4;
`endif
    localparam logic [2:0] c_st_done  = 3'd5;
    localparam logic [2:0] c_st_err   = 3'd6;

    logic [2:0]            r_state;
    logic [2:0]            w_state_nxt;
    logic                  r_we;
    logic [2:0]            r_funct3;
    logic [1:0]            r_off;
    logic [XLEN-1:0]       r_lo;
    logic [DMEM_WIDTH-1:0] r_mem_address;
    logic [XLEN-1:0]       r_mem_data;
    logic [3:0]            r_mem_byteena;

    logic [3:0]            w_size_mask;
    logic [7:0]            w_mask8;
    logic                  w_misal;
    logic                  w_bad_f3;
    logic                  w_err;
    logic                  w_accept;
    logic                  w_acc;
    logic [4:0]            w_req_sh;
    logic [DMEM_WIDTH-1:0] w_word;
    logic [XLEN-1:0]       w_wdata_lo;
    logic [2*XLEN-1:0]     w_pair;
    logic [XLEN-1:0]       w_r;
    logic [XLEN-1:0]       w_load_ext;
    logic                  w_unused;

`ifdef DMEM_MISALIGNED_EN
    logic [DMEM_WIDTH-1:0] r_word;
    logic [3:0]            r_mask_hi;
    logic                  r_misal;
    logic [XLEN-1:0]       r_wdata_hi;
    logic [XLEN-1:0]       r_hi;
    logic [2*XLEN-1:0]     w_wdata_wide;
    logic [XLEN-1:0]       w_wdata_hi;
`endif

    // Address bits above the word index are ignored by design.
    assign w_unused = ^req_addr[XLEN-1:DMEM_WIDTH+2];

    // ------------------------------------------------------------------
    // Request decode (only meaningful while IDLE)
    // ------------------------------------------------------------------
    assign w_req_sh = {req_addr[1:0], 3'b000};
    assign w_word   = req_addr[DMEM_WIDTH+1:2];
    assign w_accept = req_valid & (r_state == c_st_idle);

    // Access size as a lane mask before positioning by the byte offset.
    always_comb begin
        w_size_mask = 4'b0000;
        case (req_funct3[1:0])
            2'b00:   w_size_mask = 4'b0001;
            2'b01:   w_size_mask = 4'b0011;
            2'b10:   w_size_mask = 4'b1111;
            default: w_size_mask = 4'b0000;
        endcase
    end

    assign w_mask8  = {4'b0000, w_size_mask} << req_addr[1:0];
    assign w_misal  = |w_mask8[7:4];
    // 011/110/111 are undefined; BU/HU have no store form.
    assign w_bad_f3 = (req_funct3[1:0] == 2'b11) |
                      (req_funct3[2] & (req_funct3[1] | req_we));

`ifdef DMEM_MISALIGNED_EN
    assign w_err        = w_bad_f3;
    assign w_wdata_wide = {{XLEN{1'b0}}, req_wdata} << w_req_sh;
    assign w_wdata_lo   = w_wdata_wide[XLEN-1:0];
    assign w_wdata_hi   = w_wdata_wide[2*XLEN-1:XLEN];
`else
    assign w_err        = w_bad_f3 | w_misal;
    assign w_wdata_lo   = req_wdata << w_req_sh;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (req_valid) begin
                    w_state_nxt = w_err ? c_st_err : c_st_acc0;
                end
            end
            c_st_acc0: begin
                if (!r_we) begin
                    w_state_nxt = c_st_data0;
`ifdef DMEM_MISALIGNED_EN
                end else if (r_misal) begin
                    w_state_nxt = c_st_acc1;
`endif
                end else begin
                    w_state_nxt = c_st_done;
                end
            end
            c_st_data0: begin
`ifdef DMEM_MISALIGNED_EN
                w_state_nxt = r_misal ? c_st_acc1 : c_st_done;
`else
                w_state_nxt = c_st_done;
`endif
            end
`ifdef DMEM_MISALIGNED_EN
            c_st_acc1:  w_state_nxt = r_we ? c_st_done : c_st_data1;
            c_st_data1: w_state_nxt = c_st_done;
`endif
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------
    // State, latched request and memory-side registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_idle;
            r_we          <= 1'b0;
            r_funct3      <= 3'b000;
            r_off         <= 2'b00;
            r_lo          <= '0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_mem_byteena <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_off    <= req_addr[1:0];
                if (!w_err) begin
                    r_mem_address <= w_word;
                    r_mem_byteena <= w_mask8[3:0];
                    r_mem_data    <= req_we ? w_wdata_lo : '0;
                end
            end
`ifdef DMEM_MISALIGNED_EN
            // Second half targets the next word; the add wraps naturally.
            if ((w_state_nxt == c_st_acc1) && (r_state != c_st_acc1)) begin
                r_mem_address <= r_word + DMEM_WIDTH'(1);
                r_mem_byteena <= r_mask_hi;
                r_mem_data    <= r_we ? r_wdata_hi : '0;
            end
`endif
            if (r_state == c_st_data0) begin
                r_lo <= mem_q;
            end
        end
    end

`ifdef DMEM_MISALIGNED_EN
    // Request fields only the second half of a split access needs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_word     <= '0;
            r_mask_hi  <= 4'b0000;
            r_misal    <= 1'b0;
            r_wdata_hi <= '0;
            r_hi       <= '0;
        end else begin
            if (w_accept) begin
                r_word     <= w_word;
                r_mask_hi  <= w_mask8[7:4];
                r_misal    <= w_misal;
                r_wdata_hi <= w_wdata_hi;
            end
            if (r_state == c_st_data1) begin
                r_hi <= mem_q;
            end
        end
    end

    assign w_pair = {(r_misal ? r_hi : {XLEN{1'b0}}), r_lo};
    assign w_acc  = (r_state == c_st_acc0) | (r_state == c_st_acc1);
`else
    assign w_pair = {{XLEN{1'b0}}, r_lo};
    assign w_acc  = (r_state == c_st_acc0);
`endif

    // ------------------------------------------------------------------
    // Load data alignment and extension
    // ------------------------------------------------------------------
    assign w_r = XLEN'(w_pair >> {r_off, 3'b000});

    // Sign or zero extension selected by the latched width code.
    always_comb begin
        w_load_ext = w_r;
        case (r_funct3)
            3'b000:  w_load_ext = {{(XLEN-8){w_r[7]}}, w_r[7:0]};
            3'b100:  w_load_ext = {{(XLEN-8){1'b0}}, w_r[7:0]};
            3'b001:  w_load_ext = {{(XLEN-16){w_r[15]}}, w_r[15:0]};
            3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, w_r[15:0]};
            default: w_load_ext = w_r;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: registered or decoded from state
    // ------------------------------------------------------------------
    assign req_ready   = (r_state == c_st_idle);
    assign resp_valid  = (r_state == c_st_done) | (r_state == c_st_err);
    assign resp_err    = (r_state == c_st_err);
    assign resp_rdata  = ((r_state == c_st_done) && !r_we) ? w_load_ext : '0;
    assign mem_rden    = w_acc & ~r_we;
    assign mem_wren    = w_acc & r_we;
    assign mem_address = r_mem_address;
    assign mem_data    = r_mem_data;
    assign mem_byteena = r_mem_byteena;

endmodule
`default_nettype wire

// File: tb/tb_dmem_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_lsu_ctrl
//  Description : Self-checking bench for dmem_lsu_ctrl. A byte-addressed
//                reference memory predicts load results; a lane-sliced
//                memory model serves the DUT's port A.
//                Follows the DMEM_MISALIGNED_EN build option.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_lsu_ctrl;

    localparam int XLEN   = 32;
    localparam int DW     = 6;
    localparam int NWORDS = 1 << DW;
    localparam int NBYTES = 4 * NWORDS;
`ifdef DMEM_MISALIGNED_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [2:0]      req_funct3 = 3'b000;
    logic [XLEN-1:0] req_addr = '0;
    logic [XLEN-1:0] req_wdata = '0;
    logic            resp_valid;
    logic [XLEN-1:0] resp_rdata;
    logic            resp_err;
    logic [DW-1:0]   mem_address;
    logic [XLEN-1:0] mem_data;
    logic            mem_rden;
    logic            mem_wren;
    logic [3:0]      mem_byteena;
    logic [XLEN-1:0] mem_q;

    always #5 clk = ~clk;

    dmem_lsu_ctrl #(.XLEN(XLEN), .DMEM_WIDTH(DW)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_rden    (mem_rden),
        .mem_wren    (mem_wren),
        .mem_byteena (mem_byteena),
        .mem_q       (mem_q)
    );

    // Port-A memory: registered read, lane-masked output by live byteena
    logic [31:0] mem_arr    [NWORDS];
    logic [31:0] init_word  [NWORDS];
    logic        init_en = 1'b0;
    logic [31:0] q_reg = '0;

    always @(posedge clk) begin
        if (init_en) begin
            for (int w = 0; w < NWORDS; w++) mem_arr[w] <= init_word[w];
        end else if (mem_wren) begin
            for (int l = 0; l < 4; l++)
                if (mem_byteena[l]) mem_arr[mem_address][8*l +: 8] <= mem_data[8*l +: 8];
        end
        if (mem_rden) q_reg <= mem_arr[mem_address];
    end

    always_comb begin
        mem_q = '0;
        for (int l = 0; l < 4; l++)
            if (mem_byteena[l]) mem_q[8*l +: 8] = q_reg[8*l +: 8];
    end

    // Reference: flat byte array addressed modulo the memory size
    logic [7:0] ref_mem [NBYTES];

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int          n, off, word, lat, ns, exp_lat, exp_ns;
        bit          bad, mis, err;
        logic [3:0]  smask;
        logic [7:0]  m8;
        logic [63:0] wide;
        logic [31:0] v, exp_rd, got_rd;
        logic        got_err, got_ready;
        int          s_cyc  [4];
        logic [1:0]  s_kind [4];
        logic [DW-1:0] s_addr [4];
        logic [3:0]  s_be   [4];
        logic [31:0] s_data [4];

        case (f3[1:0])
            2'b00:   n = 1;
            2'b01:   n = 2;
            2'b10:   n = 4;
            default: n = 0;
        endcase
        bad   = (f3[1:0] == 2'b11) || (f3[2] && (f3[1] || we));
        off   = int'(addr[1:0]);
        word  = int'(addr[DW+1:2]);
        mis   = !bad && (off + n > 4);
        err   = bad || (mis && !SPLIT);
        smask = 4'((1 << n) - 1);
        m8    = {4'b0000, smask} << off;
        wide  = {32'h0, wdata} << (8 * off);
        exp_lat = err ? 1 : (we ? (mis ? 3 : 2) : (mis ? 5 : 3));
        exp_ns  = err ? 0 : (mis ? 2 : 1);

        exp_rd = '0;
        v      = '0;
        if (!err && !we) begin
            for (int i = 0; i < n; i++)
                v[8*i +: 8] = ref_mem[(int'(addr[DW+1:0]) + i) % NBYTES];
            case (f3)
                3'b000:  exp_rd = {{24{v[7]}}, v[7:0]};
                3'b100:  exp_rd = {24'h0, v[7:0]};
                3'b001:  exp_rd = {{16{v[15]}}, v[15:0]};
                3'b101:  exp_rd = {16'h0, v[15:0]};
                default: exp_rd = v;
            endcase
        end

        @(negedge clk);
        chk("ready_idle", req_ready, 1);
        chk("resp_quiet", resp_valid, 0);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        lat = 0; ns = 0; got_rd = '0; got_err = 1'b0; got_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            // Scramble the request bus so any use of unlatched fields shows.
            req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
            if ((mem_rden || mem_wren) && ns < 4) begin
                s_cyc[ns] = k; s_kind[ns] = {mem_wren, mem_rden};
                s_addr[ns] = mem_address; s_be[ns] = mem_byteena; s_data[ns] = mem_data;
                ns++;
            end
            if (resp_valid) begin
                lat = k; got_rd = resp_rdata; got_err = resp_err; got_ready = req_ready;
                break;
            end
        end

        chk("latency", lat, exp_lat);
        chk("resp_err", got_err, err);
        chk("resp_rdata", got_rd, exp_rd);
        chk("ready_busy", got_ready, 0);
        chk("n_strobes", ns, exp_ns);
        if (ns >= 1 && exp_ns >= 1) begin
            chk("s0_cycle", s_cyc[0], 1);
            chk("s0_kind", s_kind[0], we ? 2'b10 : 2'b01);
            chk("s0_addr", s_addr[0], word);
            chk("s0_byteena", s_be[0], m8[3:0]);
            if (we) chk("s0_data", s_data[0], wide[31:0]);
        end
        if (ns >= 2 && exp_ns >= 2) begin
            chk("s1_cycle", s_cyc[1], we ? 2 : 3);
            chk("s1_kind", s_kind[1], we ? 2'b10 : 2'b01);
            chk("s1_addr", s_addr[1], (word + 1) % NWORDS);
            chk("s1_byteena", s_be[1], m8[7:4]);
            if (we) chk("s1_data", s_data[1], wide[63:32]);
        end

        if (!err && we)
            for (int i = 0; i < n; i++)
                ref_mem[(int'(addr[DW+1:0]) + i) % NBYTES] = wdata[8*i +: 8];
        last_rdata = got_rd;
        last_err   = got_err;
    endtask

    // Word store interrupted by reset during its last strobe cycle
    task automatic reset_mid(input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rm_acc0_wren", mem_wren, 1);
`ifdef DMEM_MISALIGNED_EN
        @(negedge clk);
        chk("rm_acc1_wren", mem_wren, 1);
`endif
        rst = 1'b1;
        @(negedge clk);
        chk("rm_ready", req_ready, 1);
        chk("rm_wren", mem_wren, 0);
        chk("rm_rden", mem_rden, 0);
        chk("rm_resp", resp_valid, 0);
        chk("rm_addr", mem_address, 0);
        chk("rm_be", mem_byteena, 0);
        rst = 1'b0;
        // Every strobe reached the memory before reset took effect.
        for (int i = 0; i < 4; i++)
            ref_mem[(int'(addr[DW+1:0]) + i) % NBYTES] = wdata[8*i +: 8];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int w = 0; w < NWORDS; w++) begin
            init_word[w] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = init_word[w][8*b +: 8];
        end
        init_en = 1'b1;
        repeat (3) @(posedge clk);
        init_en = 1'b0;
        @(negedge clk);
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_rden", mem_rden, 0);
        chk("rst_wren", mem_wren, 0);
        chk("rst_addr", mem_address, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_be", mem_byteena, 0);
        rst = 1'b0;

        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        chk("tp_sw_err", last_err, 0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        chk("tp_lw", last_rdata, 32'hDEADBEEF);
        do_req(1'b0, 3'b000, 32'h13, 32'h0);
        chk("tp_lb", last_rdata, 32'hFFFFFFDE);
        do_req(1'b0, 3'b100, 32'h13, 32'h0);
        chk("tp_lbu", last_rdata, 32'h000000DE);
        do_req(1'b0, 3'b001, 32'h12, 32'h0);
        chk("tp_lh", last_rdata, 32'hFFFFDEAD);
        do_req(1'b1, 3'b000, 32'h11, 32'h55);
        do_req(1'b0, 3'b010, 32'h10, 32'h0);
        chk("tp_sb_lw", last_rdata, 32'hDEAD55EF);
        do_req(1'b0, 3'b011, 32'h20, 32'h0);
        chk("tp_bad_f3", last_err, 1);

        do_req(1'b1, 3'b010, 32'h0E, 32'h11223344);
        do_req(1'b0, 3'b010, 32'h0E, 32'h0);
`ifdef DMEM_MISALIGNED_EN
        chk("tp_mis_lw", last_rdata, 32'h11223344);
`else
        chk("tp_mis_err", last_err, 1);
`endif
        do_req(1'b0, 3'b001, 32'(NBYTES - 1), 32'h0);

`ifdef DMEM_MISALIGNED_EN
        reset_mid(32'h0E, 32'hA5C3_0F96);
        do_req(1'b0, 3'b010, 32'h0E, 32'h0);
        chk("tp_rm_lw", last_rdata, 32'hA5C3_0F96);
`else
        reset_mid(32'h20, 32'hA5C3_0F96);
        do_req(1'b0, 3'b010, 32'h20, 32'h0);
        chk("tp_rm_lw", last_rdata, 32'hA5C3_0F96);
`endif

        for (int t = 0; t < 400; t++)
            do_req(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
